// File: rtl/path_stack_replay.sv
`default_nettype none
// ============================================================================
// Module   : path_stack_replay
// Brief    : DFS move-path stack with forward/reverse timed replay.
// Revision : 1.0
// ============================================================================
module path_stack_replay #(
    parameter int DEPTH       = 256,
    parameter int STEP_CYCLES = 2,
    localparam int PTR_W      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [1:0]       push_move,
    input  logic             pop,
    output logic [1:0]       top_move,
    output logic [PTR_W-1:0] count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow,
    input  logic             run,
    input  logic             reverse,
    output logic [1:0]       move,
    output logic             move_valid,
    output logic             replay_busy,
    output logic             replay_done
);

    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [STEP_W-1:0] c_step_last = STEP_W'(STEP_CYCLES - 1);
    localparam logic [PTR_W-1:0]  c_depth     = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0]  c_one       = PTR_W'(1);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_REPLAY = 1'b1
    } state_t;

    state_t              r_state;
    logic [1:0]          r_mem [DEPTH];
    logic [PTR_W-1:0]    r_count;
    logic [PTR_W-1:0]    r_idx;
    logic [STEP_W-1:0]   r_step;
    logic                r_dir;
    logic                r_last;
    logic                r_ovf;
    logic                r_unf;
    logic [1:0]          r_move;
    logic                r_move_valid;
    logic                r_done;

    logic                w_empty;
    logic                w_full;
    logic [PTR_W-1:0]    w_top_ptr;
    logic                w_idle_cmd;
    logic                w_replace;
    logic                w_we;
    logic [ADDR_W-1:0]   w_waddr;
    logic [1:0]          w_rd;
    logic                w_end;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_depth);
    assign w_top_ptr  = r_count - c_one;
    assign w_idle_cmd = (r_state == S_IDLE) && !clear && !run;
    // push+pop on a non-empty stack overwrites the top in place
    assign w_replace  = push && pop && !w_empty;
    assign w_we       = w_idle_cmd && push && (w_replace || !w_full);
    assign w_waddr    = w_replace ? w_top_ptr[ADDR_W-1:0] : r_count[ADDR_W-1:0];
    assign w_rd       = r_mem[r_idx[ADDR_W-1:0]];
    assign w_end      = r_dir ? (r_idx == '0) : (r_idx == w_top_ptr);

    assign top_move    = w_empty ? 2'b00 : r_mem[w_top_ptr[ADDR_W-1:0]];
    assign count       = r_count;
    assign empty       = w_empty;
    assign full        = w_full;
    assign overflow    = r_ovf;
    assign underflow   = r_unf;
    assign move        = r_move;
    assign move_valid  = r_move_valid;
    assign replay_busy = (r_state == S_REPLAY);
    assign replay_done = r_done;

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= push_move;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_idx        <= '0;
            r_step       <= '0;
            r_dir        <= 1'b0;
            r_last       <= 1'b0;
            r_ovf        <= 1'b0;
            r_unf        <= 1'b0;
            r_move       <= 2'b00;
            r_move_valid <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_move_valid <= 1'b0;
            r_done       <= 1'b0;
            if (clear) begin
                r_state <= S_IDLE;
                r_count <= '0;
                r_ovf   <= 1'b0;
                r_unf   <= 1'b0;
                r_last  <= 1'b0;
                r_step  <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (run) begin
                            if (w_empty) begin
                                r_done <= 1'b1;
                            end else begin
                                r_state <= S_REPLAY;
                                r_dir   <= reverse;
                                r_idx   <= reverse ? w_top_ptr : '0;
                                r_step  <= '0;
                                r_last  <= 1'b0;
                            end
                        end else if (push && !w_replace) begin
                            if (w_full) begin
                                r_ovf <= 1'b1;
                            end else begin
                                r_count <= r_count + c_one;
                            end
                        end else if (pop && !push) begin
                            if (w_empty) begin
                                r_unf <= 1'b1;
                            end else begin
                                r_count <= r_count - c_one;
                            end
                        end
                    end
                    S_REPLAY: begin
                        // one extra cycle after the final move raises done as busy drops
                        if (r_last) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                            r_last  <= 1'b0;
                        end else if (r_step == '0) begin
                            r_move       <= r_dir ? (w_rd ^ 2'b10) : w_rd;
                            r_move_valid <= 1'b1;
                            r_step       <= c_step_last;
                            if (w_end) begin
                                r_last <= 1'b1;
                            end else if (r_dir) begin
                                r_idx <= r_idx - c_one;
                            end else begin
                                r_idx <= r_idx + c_one;
                            end
                        end else begin
                            r_step <= r_step - STEP_W'(1);
                        end
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_path_stack_replay.sv
`default_nettype none
// ============================================================================
// Module   : tb_path_stack_replay
// Brief    : Bench for path_stack_replay (two configurations, shared stimulus).
// Revision : 1.0
// ============================================================================
module tb_path_stack_replay;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clear = 1'b0;
    logic       push = 1'b0;
    logic [1:0] push_move = 2'b00;
    logic       pop = 1'b0;
    logic       run = 1'b0;
    logic       reverse = 1'b0;

    logic [1:0] a_top, a_move, b_top, b_move;
    logic [2:0] a_count, b_count;
    logic a_empty, a_full, a_ovf, a_unf, a_valid, a_busy, a_done;
    logic b_empty, b_full, b_ovf, b_unf, b_valid, b_busy, b_done;

    path_stack_replay #(.DEPTH(4), .STEP_CYCLES(2)) u_a (
        .clk(clk), .rst(rst), .clear(clear), .push(push), .push_move(push_move),
        .pop(pop), .top_move(a_top), .count(a_count), .empty(a_empty), .full(a_full),
        .overflow(a_ovf), .underflow(a_unf), .run(run), .reverse(reverse),
        .move(a_move), .move_valid(a_valid), .replay_busy(a_busy), .replay_done(a_done)
    );

    path_stack_replay #(.DEPTH(5), .STEP_CYCLES(1)) u_b (
        .clk(clk), .rst(rst), .clear(clear), .push(push), .push_move(push_move),
        .pop(pop), .top_move(b_top), .count(b_count), .empty(b_empty), .full(b_full),
        .overflow(b_ovf), .underflow(b_unf), .run(run), .reverse(reverse),
        .move(b_move), .move_valid(b_valid), .replay_busy(b_busy), .replay_done(b_done)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: stack as an array, replay as a precomputed move list
    // emitted on a fixed cycle schedule relative to the accepting edge.
    int dep [2] = '{4, 5};
    int stp [2] = '{2, 1};
    int mmem  [2][8];
    int mlist [2][8];
    int mcnt [2], mmove [2], mk [2], mn [2];
    bit movf [2], munf [2], mact [2], mvalid [2], mdone [2];

    task automatic model_reset(input int j);
        mcnt[j] = 0; movf[j] = 0; munf[j] = 0; mact[j] = 0;
        mvalid[j] = 0; mdone[j] = 0; mmove[j] = 0;
    endtask

    task automatic model_step(input int j);
        int d, fin;
        mvalid[j] = 0;
        mdone[j]  = 0;
        if (!rst) begin
            model_reset(j);
        end else if (clear) begin
            mcnt[j] = 0; movf[j] = 0; munf[j] = 0; mact[j] = 0;
        end else if (mact[j]) begin
            d   = cyc - mk[j];
            fin = 1 + (mn[j] - 1) * stp[j];
            if (d <= fin && ((d - 1) % stp[j]) == 0) begin
                mvalid[j] = 1;
                mmove[j]  = mlist[j][(d - 1) / stp[j]];
            end
            if (d == fin + 1) begin
                mdone[j] = 1;
                mact[j]  = 0;
            end
        end else if (run) begin
            if (mcnt[j] == 0) begin
                mdone[j] = 1;
            end else begin
                mact[j] = 1; mk[j] = cyc; mn[j] = mcnt[j];
                for (int i = 0; i < mn[j]; i++)
                    mlist[j][i] = reverse ? (mmem[j][mn[j] - 1 - i] ^ 2) : mmem[j][i];
            end
        end else if (push) begin
            if (pop && mcnt[j] > 0) mmem[j][mcnt[j] - 1] = int'(push_move);
            else if (mcnt[j] < dep[j]) begin
                mmem[j][mcnt[j]] = int'(push_move);
                mcnt[j]++;
            end else movf[j] = 1;
        end else if (pop) begin
            if (mcnt[j] > 0) mcnt[j]--;
            else munf[j] = 1;
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        model_step(0);
        model_step(1);
    end

    always @(negedge rst) begin
        model_reset(0);
        model_reset(1);
    end

    task automatic chk_inst(input int j, input int c, input int e, input int f, input int ov,
                            input int un, input int t, input int mv, input int v,
                            input int bz, input int dn);
        string p;
        p = (j == 0) ? "A" : "B";
        chk({p, ".count"}, c, mcnt[j]);
        chk({p, ".empty"}, e, int'(mcnt[j] == 0));
        chk({p, ".full"}, f, int'(mcnt[j] == dep[j]));
        chk({p, ".overflow"}, ov, int'(movf[j]));
        chk({p, ".underflow"}, un, int'(munf[j]));
        chk({p, ".top_move"}, t, (mcnt[j] == 0) ? 0 : mmem[j][mcnt[j] - 1]);
        chk({p, ".move"}, mv, mmove[j]);
        chk({p, ".move_valid"}, v, int'(mvalid[j]));
        chk({p, ".replay_busy"}, bz, int'(mact[j]));
        chk({p, ".replay_done"}, dn, int'(mdone[j]));
    endtask

    // Observed replay events of instance A, used by the directed checks.
    int aq [$];
    int acyc [$];
    int adone = 0;
    int adcyc = 0;

    always @(negedge clk) begin
        chk_inst(0, int'(a_count), int'(a_empty), int'(a_full), int'(a_ovf), int'(a_unf),
                 int'(a_top), int'(a_move), int'(a_valid), int'(a_busy), int'(a_done));
        chk_inst(1, int'(b_count), int'(b_empty), int'(b_full), int'(b_ovf), int'(b_unf),
                 int'(b_top), int'(b_move), int'(b_valid), int'(b_busy), int'(b_done));
        if (a_valid) begin
            aq.push_back(int'(a_move));
            acyc.push_back(cyc);
        end
        if (a_done) begin
            adone++;
            adcyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [1:0] m);
        push = 1'b1; push_move = m; tick(); push = 1'b0;
    endtask

    task automatic do_pop();
        pop = 1'b1; tick(); pop = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    task automatic start_run(input logic rev);
        aq.delete(); acyc.delete(); adone = 0;
        run = 1'b1; reverse = rev; tick(); run = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && adone == 0; i++) tick();
        chk("replay_done_seen", adone, 1);
        tick();
    endtask

    task automatic chk_moves(input string name, input int m0, input int m1, input int m2);
        chk({name, ".n"}, aq.size(), 3);
        if (aq.size() == 3) begin
            chk({name, ".m0"}, aq[0], m0);
            chk({name, ".m1"}, aq[1], m1);
            chk({name, ".m2"}, aq[2], m2);
            chk({name, ".gap"}, acyc[1] - acyc[0], 2);
            chk({name, ".done_lag"}, adcyc - acyc[2], 1);
        end
    endtask

    initial begin
        int r;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("rst.count", int'(a_count), 0);
        chk("rst.empty", int'(a_empty), 1);

        do_push(2'b01); do_push(2'b10); do_push(2'b11);
        do_pop(); do_pop(); do_pop();
        chk("pop3.underflow", int'(a_unf), 0);
        do_pop();
        chk("pop4.count", int'(a_count), 0);
        chk("pop4.underflow", int'(a_unf), 1);
        chk("pop4.top", int'(a_top), 0);
        chk("pop4.empty", int'(a_empty), 1);

        do_clear();
        do_push(2'b00); do_push(2'b01); do_push(2'b10); do_push(2'b11);
        chk("fill.full", int'(a_full), 1);
        chk("fill.ovf_early", int'(a_ovf), 0);
        do_push(2'b01);
        chk("fill.overflow", int'(a_ovf), 1);
        chk("fill.top", int'(a_top), 3);
        chk("fill.count", int'(a_count), 4);

        do_clear();
        do_push(2'b01); do_push(2'b10); do_push(2'b11);
        start_run(1'b0); wait_done();
        chk_moves("fwd", 1, 2, 3);
        chk("fwd.count", int'(a_count), 3);
        start_run(1'b1); wait_done();
        chk_moves("rev", 1, 0, 3);
        start_run(1'b0); wait_done();
        chk_moves("fwd2", 1, 2, 3);

        do_clear();
        do_push(2'b00);
        push = 1'b1; pop = 1'b1; push_move = 2'b11; tick(); push = 1'b0; pop = 1'b0;
        chk("repl.count", int'(a_count), 1);
        chk("repl.top", int'(a_top), 3);
        do_push(2'b01); do_push(2'b10);
        start_run(1'b0);
        pop = 1'b1; tick(); tick(); tick(); pop = 1'b0;
        wait_done();
        chk("ign.count", int'(a_count), 3);
        chk("ign.underflow", int'(a_unf), 0);

        do_clear();
        do_push(2'b01); do_push(2'b10); do_push(2'b11);
        start_run(1'b0);
        for (int i = 0; i < 40 && aq.size() < 2; i++) tick();
        chk("abort.two_moves", aq.size(), 2);
        do_clear();
        repeat (10) tick();
        chk("abort.n", aq.size(), 2);
        chk("abort.done", adone, 0);
        chk("abort.count", int'(a_count), 0);
        chk("abort.busy", int'(a_busy), 0);
        start_run(1'b0);
        tick(); tick();
        chk("empty_run.done", adone, 1);
        chk("empty_run.n", aq.size(), 0);

        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 999));
            rst       = (r < 3) ? 1'b0 : 1'b1;
            clear     = ($urandom_range(0, 99) < 2);
            push      = ($urandom_range(0, 99) < 35);
            pop       = ($urandom_range(0, 99) < 25);
            run       = ($urandom_range(0, 99) < 8);
            reverse   = 1'($urandom);
            push_move = 2'($urandom);
            tick();
        end
        rst = 1'b1; clear = 1'b0; push = 1'b0; pop = 1'b0; run = 1'b0;
        repeat (20) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/path_stack_replay.md
# path_stack_replay

Parametrised move-path store for the maze rat datapath. It holds the solver's DFS path as a stack: push on advance, pop on backtrack. Once the solver reports Done, it replays the path on `move`/`move_valid` at a programmable step rate, either forward (start→goal) or reversed (goal→start) with each move inverted. Contents survive replay, so the path can be replayed repeatedly.

## Interface
- `DEPTH`, 256: maximum stored moves (≥2); `PTR_W = $clog2(DEPTH+1)` is derived, not overridable.
- `STEP_CYCLES`, 2: clock cycles between successive replayed moves (≥1).
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `clear` in 1: synchronous flush (count=0, flags cleared, replay aborted).
- `push` in 1, `push_move` in 2: append a move (encoding 00 up, 01 right, 10 down, 11 left).
- `pop` in 1: remove the top move.
- `top_move` out 2: move at the top of the stack; 00 when empty.
- `count` out PTR_W: number of stored moves.
- `empty`, `full` out 1: `count==0` and `count==DEPTH`.
- `overflow`, `underflow` out 1: sticky error flags, cleared only by `rst`/`clear`.
- `run` in 1: start replay (level, sampled in IDLE).
- `reverse` in 1: replay direction, latched on the cycle `run` is accepted.
- `move` out 2: replayed move; holds its last value between pulses.
- `move_valid` out 1: one-cycle strobe per replayed move.
- `replay_busy` out 1: high in REPLAY.
- `replay_done` out 1: one-cycle pulse when replay completes.

## Operation
- **Reset values:**
  - `count`=0, `empty`=1, all other outputs 0, state IDLE.
  - Memory is not reset.
- **FSM states:** IDLE and REPLAY.
- **Priority each edge:** `clear` > replay control > push/pop.
- **IDLE, `push` only:**
  - if not full, `mem[count]`←`push_move` and `count`+1;
  - if full, no write and `overflow`←1.
- **IDLE, `pop` only:**
  - if not empty, `count`−1;
  - if empty, `underflow`←1.
- **IDLE, `push`&`pop` together:**
  - if not empty, replace top (`mem[count-1]`←`push_move`, `count` unchanged, no flags);
  - if empty, treat as push only (no `underflow`).
- **IDLE, `run`=1:**
  - latch `reverse` into `dir` and go to REPLAY.
  - Index = 0 (forward) or `count`−1 (reverse); step counter = 0.
  - `run` while `count`==0: stay IDLE and pulse `replay_done` next cycle, with no `move_valid`.
  - `run` has priority over a simultaneous `push`/`pop`, which is dropped.
- **REPLAY:**
  - Emit `mem[idx]` (forward) or `mem[idx]^2'b10` (reverse, i.e. up↔down, right↔left).
  - Step index toward the other end every STEP_CYCLES cycles.
  - After the last move, return to IDLE and pulse `replay_done`.
  - `push`/`pop`/`run` are ignored in REPLAY and set no flags.
  - `reverse` changes in REPLAY have no effect.
- **`clear`:**
  - count=0 and flags=0.
  - In REPLAY, abort to IDLE with no further `move_valid` and no `replay_done`.
- **`rst` asserted mid-replay:** immediate return to reset values.

## Timing
- **Push/pop:** effect visible in `count`, `top_move`, `empty`, `full` the cycle after the edge.
- `top_move` is a combinational read of `mem[count-1]` from registered `count`.
- **Replay of N moves, with `run` accepted at edge k and S=STEP_CYCLES:**
  - `move_valid` is high in the cycles following edges k+1, k+1+S, …, k+1+(N−1)S.
  - `move` is updated at those same edges.
  - `replay_busy` goes high after edge k.
  - `replay_done` is high in the cycle after the final `move_valid` cycle, coinciding with `replay_busy` falling.
- **Back-to-back replay:** `run` held high through `replay_done` restarts replay on the next IDLE cycle.
- **S=1:** one move per cycle with `move_valid` continuously high for N cycles.
- **Error flags:** set in the cycle after the offending edge.

## Test plan
- **Reset/flags:** reset, push 3 moves, pop 4 times → `count` 3→0, `underflow`=1 after the 4th pop, `top_move`=00, `empty`=1.
- **Fill/overflow:** DEPTH=4, push 5 times (00,01,10,11,01) → `full`=1 after the 4th, `overflow`=1 after the 5th, `top_move`=11, `count`=4.
- **Forward replay:** push 01,10,11; `run` 1 cycle, `reverse`=0, S=2 → `move_valid` pulses 2 cycles apart carrying 01,10,11; `replay_done` 1 cycle after the last pulse; `count` still 3.
- **Reverse replay:** same stack, `reverse`=1 → moves 01,00,11; a second forward replay after that still gives 01,10,11.
- **Replace and ignore:**
  - push 00, then `push`&`pop` with 11 → `count`=1, `top_move`=11;
  - `pop` during REPLAY → `count` unchanged, `underflow`=0.
- **Abort and empty run:**
  - `clear` after the 2nd move of a 3-move replay → no further `move_valid`, no `replay_done`, `count`=0;
  - then `run` with empty stack → `replay_done` next cycle, zero `move_valid`.
